// File: rtl/mux_n_stream.sv
// -----------------------------------------------------------------------------
// mux_n_stream
//
// N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input
// and a single registered output stage (one-entry pipeline register).
//
// Build option:
//   MUX_RR_EN  defined   -> internal round-robin arbiter selects the channel;
//                           the sel port is ignored.
//              undefined -> the channel is chosen by the sel port.
//
// Parameters:
//   WIDTH  data width per channel (>= 1)
//   N      number of input channels (>= 2)
//   SEL_W  derived, $clog2(N): select / channel-id width
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational)
//   sel        channel select (fixed-select build only)
//   out_data   registered output data
//   out_chan   registered index of the channel that supplied out_data
//   out_valid  registered output valid
//   out_ready  consumer ready
// -----------------------------------------------------------------------------
module mux_n_stream #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N*WIDTH-1:0]       in_data,
   input  logic [N-1:0]             in_valid,
   output logic [N-1:0]             in_ready,
   input  logic [$clog2(N)-1:0]     sel,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(N)-1:0]     out_chan,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int unsigned SEL_W = $clog2(N);

   logic             load;
   logic             grant_hit;
   logic [SEL_W-1:0] grant_idx;
   logic             grant_valid;
   logic [WIDTH-1:0] grant_data;
   logic             xfer;

   // The output register can take a word when empty or when it drains this cycle.
   assign load = !out_valid || out_ready;

`ifdef MUX_RR_EN
   logic [SEL_W-1:0] ptr;
   logic             unused_sel;

   assign unused_sel = ^sel;

   // Search starts one past the last granted channel, wrapping at N, so the
   // most recent winner has the lowest priority next time.
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         logic [SEL_W-1:0] cand;
         cand = SEL_W'((int'(ptr) + k) % N);
         if (!grant_hit && in_valid[cand]) begin
            grant_hit = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= SEL_W'(N - 1);
      end else if (xfer) begin
         ptr <= grant_idx;
      end
   end
`else
   // A select value at or beyond N (non power-of-two N) grants nothing.
   always_comb begin
      grant_hit = ({1'b0, sel} < (SEL_W + 1)'(N));
      grant_idx = sel;
   end
`endif

   // Gather the granted channel's valid and data with an explicit compare per
   // channel, so an out-of-range select can never index past the input vectors.
   always_comb begin
      grant_valid = 1'b0;
      grant_data  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_hit && (grant_idx == SEL_W'(i))) begin
            grant_valid = in_valid[i];
            grant_data  = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         in_ready[i] = load && grant_hit && (grant_idx == SEL_W'(i));
      end
   end

   assign xfer = load && grant_hit && grant_valid;

   // Loading without a transfer empties the register but keeps the last word
   // and channel id visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (load) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= grant_data;
            out_chan <= grant_idx;
         end
      end
   end

endmodule
